// File: rtl/mul_share_sched_if.sv
// Requester-side bundle for the shared multiplier scheduler.
// Carries the operand handshake, the result steering and the flush controls.
interface mul_share_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  flush;
  logic                  flush_done;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, flush,
    input  req_ready, rsp_valid, rsp_data,
    input  flush_done, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, flush,
    output req_ready, rsp_valid, rsp_data,
    output flush_done, busy
  );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier.
// Products return one-hot tagged after MUL_LAT cycles; flush drains the pipe.
module mul_share_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic reset,
  mul_share_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [IW-1:0]      r_rr;
  logic [IW-1:0]      w_idx;
  logic               w_hit;
  logic [NREQ-1:0]    w_gnt;
  logic [MUL_LAT-1:0] r_v;
  logic [IW-1:0]      r_tag [MUL_LAT];
  logic [PW-1:0]      r_p   [MUL_LAT];
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [PW-1:0]      w_prod;
  logic [NREQ-1:0]    w_rsp;
  logic               w_busy;

  // Circular search from r_rr; the first valid requester wins.
  always_comb begin
    int j;
    j     = 0;
    w_gnt = '0;
    w_idx = '0;
    w_hit = 1'b0;
    if (r_state == RUN && !bus.flush) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (int'(r_rr) + k) % NREQ;
        if (!w_hit && bus.req_valid[j]) begin
          w_hit = 1'b1;
          w_idx = IW'(j);
        end
      end
    end
    if (w_hit) w_gnt[w_idx] = 1'b1;
  end

  assign w_a    = bus.req_a[w_idx*WIDTH +: WIDTH];
  assign w_b    = bus.req_b[w_idx*WIDTH +: WIDTH];
  assign w_prod = PW'(w_a) * PW'(w_b);
  assign w_busy = |r_v;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_rr    <= '0;
      r_v     <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        r_tag[s] <= '0;
        r_p[s]   <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      if (w_hit) begin
        r_rr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
      r_v[0] <= w_hit;
      if (w_hit) begin
        r_tag[0] <= w_idx;
        r_p[0]   <= w_prod;
      end
      // Payload only moves with a valid, so the last stage holds the last product.
      for (int s = 1; s < MUL_LAT; s++) begin
        r_v[s] <= r_v[s-1];
        if (r_v[s-1]) begin
          r_tag[s] <= r_tag[s-1];
          r_p[s]   <= r_p[s-1];
        end
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      RUN:     if (bus.flush) w_state_nx = DRAIN;
      DRAIN:   if (!w_busy) w_state_nx = DONE;
      DONE:    if (!bus.flush) w_state_nx = RUN;
      default: w_state_nx = RUN;
    endcase
  end

  always_comb begin
    w_rsp = '0;
    if (r_v[MUL_LAT-1]) w_rsp[r_tag[MUL_LAT-1]] = 1'b1;
  end

  assign bus.req_ready  = w_gnt;
  assign bus.rsp_valid  = w_rsp;
  assign bus.rsp_data   = r_p[MUL_LAT-1];
  assign bus.busy       = w_busy;
  assign bus.flush_done = (r_state == DONE);
endmodule

// File: tb/tb_mul_share_sched.sv
// Directed testbench for mul_share_sched (NREQ=4, WIDTH=16, MUL_LAT=3).
// Each task drives one scenario and checks against hand-derived values.
module tb_mul_share_sched;
  logic clk;
  logic reset;
  int total;
  int bad;

  mul_share_sched_if #(.NREQ(4), .WIDTH(16)) tbif ();

  mul_share_sched #(
    .NREQ(4),
    .WIDTH(16),
    .MUL_LAT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(tbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tbif.req_valid = '0;
    tbif.req_a     = '0;
    tbif.req_b     = '0;
    tbif.flush     = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    #1;
    total++;
    if (tbif.rsp_valid !== 4'b0 || tbif.rsp_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp: got v=%b d=%h want v=0000 d=0",
               tbif.rsp_valid, tbif.rsp_data);
    end
    total++;
    if (tbif.busy !== 1'b0 || tbif.flush_done !== 1'b0 ||
        tbif.req_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl: got busy=%b fd=%b rdy=%b want 0 0 0000",
               tbif.busy, tbif.flush_done, tbif.req_ready);
    end
  endtask

  task automatic test_single();
    pulse_reset();
    tbif.req_valid = 4'b0001;
    tbif.req_a[15:0] = 16'd3;
    tbif.req_b[15:0] = 16'd5;
    #1;
    total++;
    if (tbif.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: got %b want 0001", tbif.req_ready);
    end
    step();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c == 3) begin
        total++;
        if (tbif.rsp_valid !== 4'b0001 || tbif.rsp_data !== 32'd15) begin
          bad++;
          $display("FAIL single_rsp: got v=%b d=%0d want v=0001 d=15",
                   tbif.rsp_valid, tbif.rsp_data);
        end
      end else begin
        total++;
        if (tbif.rsp_valid !== 4'b0) begin
          bad++;
          $display("FAIL single_quiet c%0d: got v=%b want 0000",
                   c, tbif.rsp_valid);
        end
      end
      step();
    end
    total++;
    if (tbif.rsp_data !== 32'd15) begin
      bad++;
      $display("FAIL single_hold: got d=%0d want 15", tbif.rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_tag [16];
    logic [31:0] exp_p   [16];
    int g;
    pulse_reset();
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        tbif.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
          tbif.req_a[i*16 +: 16] = 16'(100 * (i + 1) + c);
          tbif.req_b[i*16 +: 16] = 16'(3 * c + 7 + i);
        end
      end else begin
        idle_inputs();
      end
      #1;
      if (c < 8) begin
        g = c % 4;
        exp_tag[c] = 4'b0001 << g;
        exp_p[c]   = 32'((100 * (g + 1) + c) * (3 * c + 7 + g));
        total++;
        if (tbif.req_ready !== exp_tag[c]) begin
          bad++;
          $display("FAIL b2b_grant c%0d: got %b want %b",
                   c, tbif.req_ready, exp_tag[c]);
        end
      end
      if (c >= 3) begin
        total++;
        if (tbif.rsp_valid !== exp_tag[c-3] ||
            tbif.rsp_data !== exp_p[c-3]) begin
          bad++;
          $display("FAIL b2b_rsp c%0d: got v=%b d=%h want v=%b d=%h",
                   c, tbif.rsp_valid, tbif.rsp_data,
                   exp_tag[c-3], exp_p[c-3]);
        end
      end
      step();
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] want [3];
    want[0] = 4'b0010;
    want[1] = 4'b1000;
    want[2] = 4'b0010;
    pulse_reset();
    tbif.req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (tbif.req_ready !== want[c]) begin
        bad++;
        $display("FAIL skip_grant c%0d: got %b want %b",
                 c, tbif.req_ready, want[c]);
      end
      step();
    end
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_max_operands();
    pulse_reset();
    tbif.req_valid = 4'b0100;
    tbif.req_a[47:32] = 16'hFFFF;
    tbif.req_b[47:32] = 16'hFFFF;
    #1;
    total++;
    if (tbif.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL max_ready: got %b want 0100", tbif.req_ready);
    end
    step();
    idle_inputs();
    step();
    step();
    total++;
    if (tbif.rsp_valid !== 4'b0100 || tbif.rsp_data !== 32'hFFFE0001) begin
      bad++;
      $display("FAIL max_rsp: got v=%b d=%h want v=0100 d=fffe0001",
               tbif.rsp_valid, tbif.rsp_data);
    end
  endtask

  task automatic test_flush();
    pulse_reset();
    tbif.req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tbif.req_a[15:0] = 16'(c + 2);
      tbif.req_b[15:0] = 16'd3;
      if (c == 3) tbif.flush = 1'b1;
      if (c == 7) begin
        #1;
        total++;
        if (tbif.flush_done !== 1'b1 || tbif.busy !== 1'b0) begin
          bad++;
          $display("FAIL flush_done c7: got fd=%b busy=%b want 1 0",
                   tbif.flush_done, tbif.busy);
        end
        tbif.flush = 1'b0;
      end
      #1;
      if (c < 3) begin
        total++;
        if (tbif.req_ready !== 4'b0001) begin
          bad++;
          $display("FAIL flush_issue c%0d: got %b want 0001",
                   c, tbif.req_ready);
        end
      end else if (c <= 7) begin
        total++;
        if (tbif.req_ready !== 4'b0000) begin
          bad++;
          $display("FAIL flush_gate c%0d: got %b want 0000",
                   c, tbif.req_ready);
        end
      end
      if (c >= 3 && c <= 5) begin
        total++;
        if (tbif.rsp_valid !== 4'b0001 ||
            tbif.rsp_data !== 32'((c - 3 + 2) * 3)) begin
          bad++;
          $display("FAIL flush_rsp c%0d: got v=%b d=%0d want v=0001 d=%0d",
                   c, tbif.rsp_valid, tbif.rsp_data, (c - 3 + 2) * 3);
        end
      end
      if (c == 6) begin
        total++;
        if (tbif.flush_done !== 1'b0 || tbif.busy !== 1'b0 ||
            tbif.rsp_valid !== 4'b0) begin
          bad++;
          $display("FAIL flush_empty c6: got fd=%b busy=%b v=%b want 0 0 0000",
                   tbif.flush_done, tbif.busy, tbif.rsp_valid);
        end
      end
      if (c == 8) begin
        total++;
        if (tbif.flush_done !== 1'b0 || tbif.req_ready !== 4'b0001) begin
          bad++;
          $display("FAIL flush_resume c8: got fd=%b rdy=%b want 0 0001",
                   tbif.flush_done, tbif.req_ready);
        end
      end
      step();
    end
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_reset_inflight();
    pulse_reset();
    tbif.req_valid = 4'b0011;
    tbif.req_a[15:0]  = 16'd7;
    tbif.req_b[15:0]  = 16'd9;
    tbif.req_a[31:16] = 16'd11;
    tbif.req_b[31:16] = 16'd13;
    step();
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total++;
    if (tbif.rsp_data !== 32'h0 || tbif.busy !== 1'b0 ||
        tbif.flush_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_inflight_out: got d=%h busy=%b fd=%b want 0 0 0",
               tbif.rsp_data, tbif.busy, tbif.flush_done);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (tbif.rsp_valid !== 4'b0) begin
        bad++;
        $display("FAIL rst_inflight_rsp c%0d: got %b want 0000",
                 c, tbif.rsp_valid);
      end
      step();
    end
    tbif.req_valid = 4'b1111;
    #1;
    total++;
    if (tbif.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rst_inflight_grant: got %b want 0001", tbif.req_ready);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();
    step();
    test_reset();
    test_single();
    test_back_to_back();
    test_skip_wrap();
    test_max_operands();
    test_flush();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
